ii_rect_sum_engine: RTL and testbench

II_RECT_SUM_ENGINE -- requirements
Module: ii_rect_sum_engine

---
 rtl/ii_rect_sum_engine.sv | 150 +++++++++++++++
 tb/tb_ii_rect_sum_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ii_rect_sum_engine.sv
// Rectangle sum engine over an integral image buffer.
// Four reads (D, C, B, A) per request; result is D-C-B+A.
module ii_rect_sum_engine #(
   parameter int IMG_W = 160,
   parameter int IMG_H = 120,
   localparam int XW = $clog2(IMG_W),
   localparam int WW = $clog2(IMG_W + 1),
   localparam int YW = $clog2(IMG_H),
   localparam int HW = $clog2(IMG_H + 1),
   localparam int AW = $clog2(IMG_W * IMG_H),
   localparam int DW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [XW-1:0] req_x,
   input  logic [YW-1:0] req_y,
   input  logic [WW-1:0] req_w,
   input  logic [HW-1:0] req_h,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] ii_rddata,
   output logic          sum_valid,
   output logic [DW-1:0] sum_data,
   output logic          sum_err,
   output logic          busy
);

   typedef enum logic [2:0] {
      IDLE, RD_D, RD_C, RD_B, RD_A, ERR
   } state_t;

   localparam logic [31:0] LW = IMG_W;

   state_t        r_state;
   state_t        w_next;
   logic [XW-1:0] r_xe, r_xm;
   logic [YW-1:0] r_ye, r_ym;
   logic          r_x0, r_y0;
   logic [DW-1:0] r_acc;
   logic          r_fin;
   logic          r_err_pend;
   logic          r_sum_valid;
   logic          r_sum_err;
   logic [DW-1:0] r_sum_data;

   logic          w_accept;
   logic          w_bad;
   logic [XW-1:0] w_col;
   logic [YW-1:0] w_row;
   logic          w_zero;
   logic [AW-1:0] w_rowmul;

   assign w_accept = req_valid && (r_state == IDLE);
   assign w_bad = (req_w == '0) || (req_h == '0)
               || (int'(req_x) + int'(req_w) > IMG_W)
               || (int'(req_y) + int'(req_h) > IMG_H);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_next = w_bad ? ERR : RD_D;
         RD_D:    w_next = RD_C;
         RD_C:    w_next = RD_B;
         RD_B:    w_next = RD_A;
         RD_A:    w_next = IDLE;
         ERR:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Terms left of column 0 or above row 0 read address 0 and are masked.
   always_comb begin
      w_col  = '0;
      w_row  = '0;
      w_zero = 1'b1;
      unique case (r_state)
         RD_D: begin w_col = r_xe; w_row = r_ye; w_zero = 1'b0; end
         RD_C: begin w_col = r_xm; w_row = r_ye; w_zero = r_x0; end
         RD_B: begin w_col = r_xe; w_row = r_ym; w_zero = r_y0; end
         RD_A: begin w_col = r_xm; w_row = r_ym; w_zero = r_x0 | r_y0; end
         default: ;
      endcase
   end

   // Constant-coefficient shift-add: (r<<7)+(r<<5) for width 160.
   always_comb begin
      w_rowmul = '0;
      for (int i = 0; i < AW; i++) begin
         if (LW[i]) w_rowmul = w_rowmul + (AW'(w_row) << i);
      end
   end

   assign rd_addr = w_zero ? '0 : w_rowmul + AW'(w_col);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_xe        <= '0;
         r_xm        <= '0;
         r_ye        <= '0;
         r_ym        <= '0;
         r_x0        <= 1'b0;
         r_y0        <= 1'b0;
         r_acc       <= '0;
         r_fin       <= 1'b0;
         r_err_pend  <= 1'b0;
         r_sum_valid <= 1'b0;
         r_sum_err   <= 1'b0;
         r_sum_data  <= '0;
      end else begin
         r_state     <= w_next;
         r_fin       <= (r_state == RD_A);
         r_sum_valid <= 1'b0;
         if (w_accept) begin
            r_xe <= XW'(int'(req_x) + int'(req_w) - 1);
            r_xm <= req_x - XW'(1);
            r_ye <= YW'(int'(req_y) + int'(req_h) - 1);
            r_ym <= req_y - YW'(1);
            r_x0 <= (req_x == '0);
            r_y0 <= (req_y == '0);
         end
         unique case (r_state)
            RD_C: r_acc <= ii_rddata;
            RD_B: r_acc <= r_acc - (r_x0 ? '0 : ii_rddata);
            RD_A: r_acc <= r_acc - (r_y0 ? '0 : ii_rddata);
            default: ;
         endcase
         // A reject accepted on the result edge reports one cycle late.
         if (r_fin) begin
            r_sum_valid <= 1'b1;
            r_sum_err   <= 1'b0;
            r_sum_data  <= r_acc + ((r_x0 | r_y0) ? '0 : ii_rddata);
         end else if ((w_accept && w_bad)
                   || (r_state == ERR && r_err_pend)) begin
            r_sum_valid <= 1'b1;
            r_sum_err   <= 1'b1;
            r_sum_data  <= '0;
         end
         r_err_pend <= w_accept && w_bad && r_fin;
      end
   end

   assign req_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign sum_valid = r_sum_valid;
   assign sum_err   = r_sum_err;
   assign sum_data  = r_sum_data;

endmodule

// File: tb/tb_ii_rect_sum_engine.sv
// Bench for ii_rect_sum_engine: directed and random rectangles
// checked against a direct pixel-sum reference.
module tb_ii_rect_sum_engine;
   localparam int W = 160;
   localparam int H = 120;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_x;
   logic [6:0]  req_y;
   logic [7:0]  req_w;
   logic [6:0]  req_h;
   logic [14:0] rd_addr;
   logic [19:0] ii_rddata;
   logic        sum_valid;
   logic [19:0] sum_data;
   logic        sum_err;
   logic        busy;

   ii_rect_sum_engine #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
      .rd_addr(rd_addr), .ii_rddata(ii_rddata),
      .sum_valid(sum_valid), .sum_data(sum_data),
      .sum_err(sum_err), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [19:0] mem [W*H];
   int pix [H][W];
   int iiv [H][W];

   always @(posedge clk) ii_rddata <= mem[rd_addr];

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   int          ra [6];
   logic [5:0]  sv, se, bz, rr;
   logic [19:0] sd [6];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input bit rnd, input int val);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            pix[r][c] = rnd ? int'($urandom_range(0, 15)) : val;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            iiv[r][c] = pix[r][c];
            if (r > 0) iiv[r][c] += iiv[r-1][c];
            if (c > 0) iiv[r][c] += iiv[r][c-1];
            if (r > 0 && c > 0) iiv[r][c] -= iiv[r-1][c-1];
            mem[r*W + c] = 20'(iiv[r][c]);
         end
   endtask

   function automatic int ref_sum(input int x, y, w, h);
      int s = 0;
      for (int r = y; r < y + h; r++)
         for (int c = x; c < x + w; c++) s += pix[r][c];
      return s;
   endfunction

   function automatic int ea(input int c, r);
      return (c < 0 || r < 0) ? 0 : r * W + c;
   endfunction

   task automatic run(input int x, y, w, h);
      @(negedge clk);
      req_x = 8'(x); req_y = 7'(y);
      req_w = 8'(w); req_h = 7'(h);
      req_valid = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) req_valid = 1'b0;
         ra[k] = int'(rd_addr);
         sv[k] = sum_valid;
         se[k] = sum_err;
         sd[k] = sum_data;
         bz[k] = busy;
         rr[k] = req_ready;
      end
   endtask

   task automatic good(input string t, input int x, y, w, h);
      run(x, y, w, h);
      chk({t, ".addrD"}, ra[0], ea(x + w - 1, y + h - 1));
      chk({t, ".addrC"}, ra[1], ea(x - 1, y + h - 1));
      chk({t, ".addrB"}, ra[2], ea(x + w - 1, y - 1));
      chk({t, ".addrA"}, ra[3], ea(x - 1, y - 1));
      chk({t, ".vpulse"}, sv, 6'b100000);
      chk({t, ".busy"}, bz, 6'b001111);
      chk({t, ".ready"}, rr, 6'b110000);
      chk({t, ".data"}, sd[5], ref_sum(x, y, w, h));
      chk({t, ".err"}, se[5], 1'b0);
   endtask

   task automatic bad(input string t, input int x, y, w, h);
      run(x, y, w, h);
      chk({t, ".vpulse"}, sv, 6'b000001);
      chk({t, ".err"}, se[0], 1'b1);
      chk({t, ".data"}, sd[0], 0);
      chk({t, ".addr"}, ra[0] + ra[1], 0);
      chk({t, ".busy"}, bz, 6'b000001);
   endtask

   int bx [3] = '{0, 10, 150};
   int by [3] = '{0, 20, 110};
   int bw [3] = '{5, 8, 10};
   int bh [3] = '{5, 4, 10};

   initial begin
      int k, nr, x, y, w, h, hits;
      int ac [3];
      int rc [3];
      logic [19:0] rdv [3];
      logic wa, okrb;

      rst = 1'b1; req_valid = 1'b0;
      req_x = '0; req_y = '0; req_w = '0; req_h = '0;
      fill(1'b0, 1);
      repeat (2) @(negedge clk);
      chk("rst.ready", req_ready, 1'b1);
      chk("rst.busy", busy, 1'b0);
      chk("rst.addr", rd_addr, 0);
      chk("rst.outs", {sum_valid, sum_err, sum_data}, 0);
      rst = 1'b0;

      good("ones", 10, 20, 8, 4);
      chk("ones.exact", sd[5], 32);
      chk("ones.d", ra[0], 3697);
      chk("ones.a", ra[3], 3049);
      @(negedge clk);
      chk("ones.hold", sum_data, 32);

      fill(1'b0, 15);
      good("full", 0, 0, W, H);
      chk("full.exact", sd[5], 288000);
      good("inner", 1, 1, 159, 119);
      chk("inner.exact", sd[5], 283815);
      good("corner", 159, 119, 1, 1);

      bad("xover", 150, 5, 11, 3);
      bad("w0", 3, 3, 0, 4);
      bad("h0", 3, 3, 4, 0);
      bad("yover", 0, 100, 5, 21);

      fill(1'b1, 0);
      for (int i = 0; i < 16; i++) begin
         x = $urandom_range(0, W - 1);
         y = $urandom_range(0, H - 1);
         w = $urandom_range(1, W - x);
         h = $urandom_range(1, H - y);
         if (i % 4 == 3) begin
            if ($urandom_range(0, 1) == 1) w = $urandom_range(W + 1 - x, 255);
            else h = $urandom_range(H + 1 - y, 127);
            bad($sformatf("rbad%0d", i), x, y, w, h);
         end else begin
            good($sformatf("rnd%0d", i), x, y, w, h);
         end
      end

      @(negedge clk);
      k = 0; nr = 0; okrb = 1'b1;
      ac = '{-100, -100, -100};
      rc = '{-200, -200, -200};
      req_x = 8'(bx[0]); req_y = 7'(by[0]);
      req_w = 8'(bw[0]); req_h = 7'(bh[0]);
      req_valid = 1'b1;
      for (int c = 0; c < 25; c++) begin
         wa = req_valid && req_ready;
         @(posedge clk);
         @(negedge clk);
         if (busy === req_ready) okrb = 1'b0;
         if (wa) begin
            ac[k] = c;
            k++;
            if (k < 3) begin
               req_x = 8'(bx[k]); req_y = 7'(by[k]);
               req_w = 8'(bw[k]); req_h = 7'(bh[k]);
            end else req_valid = 1'b0;
         end
         if (sum_valid === 1'b1 && nr < 3) begin
            rc[nr] = c; rdv[nr] = sum_data; nr++;
         end
      end
      chk("b2b.accepts", k, 3);
      chk("b2b.gap1", ac[1] - ac[0], 5);
      chk("b2b.gap2", ac[2] - ac[1], 5);
      chk("b2b.results", nr, 3);
      chk("b2b.readybusy", okrb, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2b.lat%0d", i), rc[i] - ac[i], 5);
         chk($sformatf("b2b.data%0d", i), rdv[i],
             ref_sum(bx[i], by[i], bw[i], bh[i]));
      end

      @(negedge clk);
      req_x = 8'd10; req_y = 7'd20; req_w = 8'd8; req_h = 7'd4;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst.ready", req_ready, 1'b1);
      chk("mrst.busy", busy, 1'b0);
      chk("mrst.addr", rd_addr, 0);
      chk("mrst.outs", {sum_valid, sum_err, sum_data}, 0);
      @(negedge clk);
      rst = 1'b0;
      hits = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (sum_valid !== 1'b0) hits++;
      end
      chk("mrst.nopulse", hits, 0);
      good("after_rst", 10, 20, 8, 4);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
